// File: rtl/aes_axi_slave.sv
// AXI4-Lite slave bridging bus writes/reads onto the AES core register file.
// Independent write and read FSMs; writes are withheld while the core owns the register file.
module aes_axi_slave #(
  parameter logic [7:0] STATUS_ADDR = 8'h4C
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic [31:0] AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [31:0] ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic        core_busy,
  output logic        enable_amba,
  output logic        wr_amba,
  output logic [31:0] addr_wc,
  output logic [31:0] data_in,
  output logic [3:0]  strb,
  output logic [31:0] addr_rc,
  input  logic [31:0] data_out
);

  typedef enum logic [2:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  w_state_t    r_wstate, w_wnext;
  r_state_t    r_rstate, w_rnext;
  logic [31:0] r_awaddr, r_wdata, r_araddr, r_rdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_bresp, r_rresp;
  logic        w_aw_hs, w_w_hs, w_ar_hs;
  logic        w_oor, w_reject, w_leave_commit;

  assign w_aw_hs        = AWVALID && AWREADY;
  assign w_w_hs         = WVALID && WREADY;
  assign w_ar_hs        = ARVALID && ARREADY;
  assign w_oor          = (r_awaddr[7:0] >= STATUS_ADDR);
  assign w_reject       = w_oor || (r_wstrb == 4'h0);
  // Rejected writes never touch the register file, so they need not wait for the core.
  assign w_leave_commit = (r_wstate == W_COMMIT) && (w_reject || !core_busy);

  assign enable_amba = !core_busy;
  assign addr_wc     = r_awaddr;
  assign data_in     = r_wdata;
  assign strb        = r_wstrb;
  assign addr_rc     = r_araddr;
  assign BRESP       = r_bresp;
  assign RDATA       = r_rdata;
  assign RRESP       = r_rresp;

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
    end
  end

  always_comb begin
    w_wnext = r_wstate;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    wr_amba = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        AWREADY = !ARST;
        WREADY  = !ARST;
        if (w_aw_hs && w_w_hs) w_wnext = W_COMMIT;
        else if (w_aw_hs)      w_wnext = W_WAIT_W;
        else if (w_w_hs)       w_wnext = W_WAIT_AW;
      end
      W_WAIT_W: begin
        WREADY = !ARST;
        if (w_w_hs) w_wnext = W_COMMIT;
      end
      W_WAIT_AW: begin
        AWREADY = !ARST;
        if (w_aw_hs) w_wnext = W_COMMIT;
      end
      W_COMMIT: begin
        wr_amba = !ARST && !w_reject && !core_busy;
        if (w_leave_commit) w_wnext = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  always_comb begin
    w_rnext = r_rstate;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        ARREADY = !ARST;
        if (w_ar_hs) w_rnext = R_FETCH;
      end
      R_FETCH: w_rnext = R_DATA;
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY) w_rnext = R_IDLE;
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= '0;
    end else begin
      if (w_aw_hs) r_awaddr <= AWADDR;
      if (w_w_hs) begin
        r_wdata <= WDATA;
        r_wstrb <= WSTRB;
      end
      if (w_leave_commit) r_bresp <= w_oor ? 2'b10 : 2'b00;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      r_araddr <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else begin
      if (w_ar_hs) r_araddr <= ARADDR;
      if (r_rstate == R_FETCH) begin
        if (r_araddr[7:0] <= STATUS_ADDR) begin
          r_rdata <= data_out;
          r_rresp <= 2'b00;
        end else begin
          r_rdata <= '0;
          r_rresp <= 2'b10;
        end
      end
    end
  end

endmodule
